// File: rtl/product_accumulator.sv
// product_accumulator
//   Accumulate half of the MAC datapath. Sums a group of unsigned products
//   arriving one per cycle on a valid/ready port. A group closes on in_last
//   or when it reaches MAX_COUNT terms. The closing sum, term count and wrap
//   flag are then held on a registered valid/ready result port.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   clear               synchronous abort of partial group and held result
//   in_valid/in_ready   product handshake (in_ready is combinational)
//   in_product, in_last product beat and group terminator
//   out_valid/out_ready result handshake
//   out_sum             group sum modulo 2^ACC_WIDTH
//   out_count           terms in the group (1..MAX_COUNT)
//   out_overflow        sum wrapped at least once within the group
module product_accumulator #(
  parameter  int PRODUCT_WIDTH = 16,
  parameter  int ACC_WIDTH     = 24,
  parameter  int MAX_COUNT     = 16,
  localparam int CNT_WIDTH     = $clog2(MAX_COUNT + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [PRODUCT_WIDTH-1:0] in_product,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ACC_WIDTH-1:0]     out_sum,
  output logic [CNT_WIDTH-1:0]     out_count,
  output logic                     out_overflow
);

  if (ACC_WIDTH < PRODUCT_WIDTH) begin : g_bad_acc
    $error("product_accumulator: ACC_WIDTH must be >= PRODUCT_WIDTH");
  end
  if (MAX_COUNT < 1) begin : g_bad_max
    $error("product_accumulator: MAX_COUNT must be >= 1");
  end

  localparam logic [CNT_WIDTH-1:0] MAXC = CNT_WIDTH'(MAX_COUNT);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t                 r_state, w_next_state;
  logic [ACC_WIDTH-1:0]   r_acc;
  logic [CNT_WIDTH-1:0]   r_cnt;
  logic                   r_ovf;

  logic                   w_accept;
  logic                   w_start;
  logic                   w_close;
  logic [ACC_WIDTH:0]     w_prod_ext;
  logic [ACC_WIDTH:0]     w_sum;
  logic [ACC_WIDTH-1:0]   w_acc_nxt;
  logic [CNT_WIDTH-1:0]   w_cnt_nxt;
  logic                   w_ovf_nxt;

  // Stalls only while a result is held and downstream is not taking it.
  assign in_ready = (r_state != HOLD) || out_ready;
  assign w_accept = in_valid && in_ready && !clear;

  // Any beat accepted outside ACCUM is the first term of a new group.
  assign w_start    = (r_state != ACCUM);
  assign w_prod_ext = (ACC_WIDTH+1)'(in_product);
  assign w_sum      = {1'b0, r_acc} + w_prod_ext;
  assign w_acc_nxt  = w_start ? w_prod_ext[ACC_WIDTH-1:0] : w_sum[ACC_WIDTH-1:0];
  assign w_cnt_nxt  = w_start ? CNT_WIDTH'(1) : r_cnt + CNT_WIDTH'(1);
  assign w_ovf_nxt  = !w_start && (r_ovf || w_sum[ACC_WIDTH]);
  assign w_close    = w_accept && (in_last || (w_cnt_nxt == MAXC));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    if (clear)                            w_next_state = IDLE;
    else if (w_accept)                    w_next_state = w_close ? HOLD : ACCUM;
    else if (r_state == HOLD && out_ready) w_next_state = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc        <= '0;
      r_cnt        <= '0;
      r_ovf        <= 1'b0;
      out_valid    <= 1'b0;
      out_sum      <= '0;
      out_count    <= '0;
      out_overflow <= 1'b0;
    end else begin
      out_valid <= (w_next_state == HOLD);
      if (clear) begin
        r_acc <= '0;
        r_cnt <= '0;
        r_ovf <= 1'b0;
      end else if (w_accept) begin
        r_acc <= w_acc_nxt;
        r_cnt <= w_cnt_nxt;
        r_ovf <= w_ovf_nxt;
      end
      // Result registers change only on a close, so they hold through backpressure.
      if (w_close) begin
        out_sum      <= w_acc_nxt;
        out_count    <= w_cnt_nxt;
        out_overflow <= w_ovf_nxt;
      end
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
module tb_product_accumulator;
  localparam int PW = 16;
  localparam int AW = 16;
  localparam int MC = 16;
  localparam int CW = $clog2(MC + 1);

  logic          clk = 0;
  logic          rst_n = 0;
  logic          clear = 0;
  logic          in_valid = 0;
  logic          in_ready;
  logic [PW-1:0] in_product = '0;
  logic          in_last = 0;
  logic          out_valid;
  logic          out_ready = 1;
  logic [AW-1:0] out_sum;
  logic [CW-1:0] out_count;
  logic          out_overflow;

  product_accumulator #(.PRODUCT_WIDTH(PW), .ACC_WIDTH(AW), .MAX_COUNT(MC)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_product(in_product), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_count(out_count), .out_overflow(out_overflow)
  );

  always #5 clk = ~clk;

  typedef struct { int sum; int cnt; bit ovf; } res_t;
  res_t q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cycles   = 0;
  bit accepted;

  // reference model of the group in progress
  int m_acc = 0;
  int m_cnt = 0;
  bit m_ovf = 0;

  // Advance one clock. At the negedge sample the handshakes; a result transfer
  // pops the scoreboard and is compared there. Returns at posedge + 1.
  task automatic tick();
    res_t e;
    @(negedge clk);
    accepted = in_valid && in_ready && !clear;
    if (rst_n && out_valid && out_ready) begin
      n_checks++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got sum=%0d cnt=%0d ovf=%0b, none expected",
                 out_sum, out_count, out_overflow);
      end else begin
        e = q.pop_front();
        if (out_sum !== AW'(e.sum) || out_count !== CW'(e.cnt) || out_overflow !== e.ovf) begin
          n_fail++;
          $display("FAIL sb_result: got sum=%0d cnt=%0d ovf=%0b, want sum=%0d cnt=%0d ovf=%0b",
                   out_sum, out_count, out_overflow, e.sum, e.cnt, e.ovf);
        end
      end
    end
    @(posedge clk);
    #1;
    cycles++;
  endtask

  task automatic model_beat(input int p, input bit last);
    res_t r;
    if (m_cnt == 0) begin
      m_acc = p; m_cnt = 1; m_ovf = 0;
    end else begin
      m_acc = m_acc + p;
      if (m_acc >= (1 << AW)) begin m_acc = m_acc - (1 << AW); m_ovf = 1; end
      m_cnt++;
    end
    if (last || m_cnt == MC) begin
      r.sum = m_acc; r.cnt = m_cnt; r.ovf = m_ovf;
      q.push_back(r);
      m_cnt = 0;
    end
  endtask

  // Present one beat and hold it until accepted (bounded).
  task automatic send(input int p, input bit last);
    int guard = 0;
    in_valid = 1; in_product = PW'(p); in_last = last;
    forever begin
      tick();
      if (accepted) break;
      guard++;
      if (guard > 50) begin
        n_checks++; n_fail++;
        $display("FAIL send_timeout: beat %0d not accepted, want accepted within 50 cycles", p);
        break;
      end
    end
    if (accepted) model_beat(p, last);
    in_valid = 0; in_last = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    #1;
    n_checks++;
    if (out_valid !== 0 || out_sum !== 0 || out_count !== 0 || out_overflow !== 0 || in_ready !== 1) begin
      n_fail++;
      $display("FAIL reset_state: got v=%0b s=%0d c=%0d o=%0b rdy=%0b, want 0 0 0 0 1",
               out_valid, out_sum, out_count, out_overflow, in_ready);
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    tick();
  endtask

  task automatic test_basic();
    out_ready = 1;
    send(3, 0); send(5, 0); send(7, 1);
    n_checks++;
    if (out_valid !== 1 || out_sum !== 15 || out_count !== 3 || out_overflow !== 0) begin
      n_fail++;
      $display("FAIL basic_group: got v=%0b s=%0d c=%0d o=%0b, want 1 15 3 0",
               out_valid, out_sum, out_count, out_overflow);
    end
    tick();
    n_checks++;
    if (out_valid !== 0) begin
      n_fail++;
      $display("FAIL basic_idle: got out_valid=%0b, want 0", out_valid);
    end
  endtask

  task automatic test_max_count();
    for (int i = 0; i < MC; i++) send(1, 0);
    n_checks++;
    if (out_valid !== 1 || out_sum !== 16 || out_count !== 16) begin
      n_fail++;
      $display("FAIL max_close: got v=%0b s=%0d c=%0d, want 1 16 16", out_valid, out_sum, out_count);
    end
    send(1, 1);
    n_checks++;
    if (out_valid !== 1 || out_sum !== 1 || out_count !== 1) begin
      n_fail++;
      $display("FAIL max_next_group: got v=%0b s=%0d c=%0d, want 1 1 1", out_valid, out_sum, out_count);
    end
    tick();
  endtask

  task automatic test_overflow();
    send('hFFFF, 0); send(2, 1);
    n_checks++;
    if (out_sum !== 16'h0001 || out_overflow !== 1 || out_count !== 2) begin
      n_fail++;
      $display("FAIL ovf_wrap: got s=%0h o=%0b c=%0d, want 1 1 2", out_sum, out_overflow, out_count);
    end
    send(5, 1);
    n_checks++;
    if (out_sum !== 5 || out_overflow !== 0) begin
      n_fail++;
      $display("FAIL ovf_reset_next: got s=%0d o=%0b, want 5 0", out_sum, out_overflow);
    end
    tick();
  endtask

  task automatic test_backpressure();
    out_ready = 0;
    send(4, 0); send(6, 1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1; in_product = 16'd77; in_last = 1;
      tick();
      n_checks++;
      if (accepted || in_ready !== 0 || out_valid !== 1 || out_sum !== 10 || out_count !== 2) begin
        n_fail++;
        $display("FAIL bp_stall%0d: got acc=%0b rdy=%0b v=%0b s=%0d c=%0d, want 0 0 1 10 2",
                 i, accepted, in_ready, out_valid, out_sum, out_count);
      end
    end
    out_ready = 1;
    send(9, 1);
    n_checks++;
    if (out_valid !== 1 || out_sum !== 9 || out_count !== 1) begin
      n_fail++;
      $display("FAIL bp_release: got v=%0b s=%0d c=%0d, want 1 9 1", out_valid, out_sum, out_count);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int start;
    out_ready = 1;
    start = cycles;
    for (int i = 1; i <= 8; i++) begin
      send(i, 1);
      n_checks++;
      if (out_valid !== 1 || out_sum !== AW'(i) || out_count !== 1) begin
        n_fail++;
        $display("FAIL b2b_beat%0d: got v=%0b s=%0d c=%0d, want 1 %0d 1", i, out_valid, out_sum, out_count, i);
      end
    end
    n_checks++;
    if (cycles - start !== 8) begin
      n_fail++;
      $display("FAIL b2b_rate: got %0d cycles, want 8", cycles - start);
    end
    tick();
  endtask

  task automatic test_clear();
    send(4, 0); send(4, 0);
    clear = 1;
    tick();
    clear = 0; m_cnt = 0;
    send(2, 1);
    n_checks++;
    if (out_sum !== 2 || out_count !== 1) begin
      n_fail++;
      $display("FAIL clear_abort: got s=%0d c=%0d, want 2 1", out_sum, out_count);
    end
    // held result transfers during this clear; the presented beat is dropped
    clear = 1; in_valid = 1; in_product = 16'd9; in_last = 1;
    tick();
    clear = 0; in_valid = 0; in_last = 0;
    n_checks++;
    if (out_valid !== 0) begin
      n_fail++;
      $display("FAIL clear_drop: got out_valid=%0b, want 0", out_valid);
    end
    tick();
    n_checks++;
    if (out_valid !== 0) begin
      n_fail++;
      $display("FAIL clear_drop_late: got out_valid=%0b, want 0", out_valid);
    end
  endtask

  task automatic test_reset_hold();
    out_ready = 0;
    send(6, 1);
    n_checks++;
    if (out_valid !== 1) begin
      n_fail++;
      $display("FAIL rst_hold_pre: got out_valid=%0b, want 1", out_valid);
    end
    #2 rst_n = 0;
    #1;
    n_checks++;
    if (out_valid !== 0 || out_sum !== 0 || in_ready !== 1) begin
      n_fail++;
      $display("FAIL rst_hold: got v=%0b s=%0d rdy=%0b, want 0 0 1", out_valid, out_sum, in_ready);
    end
    q.delete(); m_cnt = 0;
    @(posedge clk);
    #1 rst_n = 1;
    out_ready = 1;
    tick();
    send(8, 1);
    n_checks++;
    if (out_sum !== 8 || out_count !== 1 || out_overflow !== 0) begin
      n_fail++;
      $display("FAIL rst_recover: got s=%0d c=%0d o=%0b, want 8 1 0", out_sum, out_count, out_overflow);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max_count();
    test_overflow();
    test_backpressure();
    test_back_to_back();
    test_clear();
    test_reset_hold();
    repeat (3) tick();
    n_checks++;
    if (q.size() !== 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d results pending, want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
